// File: rtl/q_timing_issuer.sv
// Timed event issuer: events are queued with a label timestamp and issued
// once the free-running timeline reaches that timestamp.
module q_timing_issuer #(
  parameter int DEPTH = 8,
  parameter int TW    = 24,
  parameter int PW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          q_time_write,
  input  logic [19:0]   wait_val,
  input  logic [1:0]    q_reg_write,
  input  logic          q_slm,
  input  logic          q_rot,
  input  logic [PW-1:0] q_payload,
  output logic          stall,
  output logic          ev_valid,
  output logic [3:0]    ev_type,
  output logic [PW-1:0] ev_payload,
  output logic          busy,
  output logic          late_err,
  output logic          ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TW + 4 + PW;
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timeline;
  logic [TW-1:0] label_time;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [EW-1:0] head;
  logic [TW-1:0] head_ts;
  logic          full;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          to_idle;

  always_comb begin
    head     = mem[rd_ptr];
    head_ts  = head[EW-1 -: TW];
    full     = (count == CNT_FULL);
    pop      = (state != IDLE) && (count != '0) && (timeline >= head_ts);
    push_req = (q_reg_write != 2'b00);
    // a pop in the same cycle frees a slot, so a full FIFO can still accept
    push     = push_req && (!full || pop);
    to_idle  = (state == DRAIN) && (count == '0);
  end

  assign stall = full;
  assign busy  = (state != IDLE) || (count != '0);

  // Storage carries no reset; occupancy is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {label_time, q_reg_write, q_slm, q_rot, q_payload};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timeline   <= '0;
      label_time <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ev_valid   <= 1'b0;
      ev_type    <= '0;
      ev_payload <= '0;
      late_err   <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (stop) state <= DRAIN;
        DRAIN:   if (to_idle) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (to_idle)
        timeline <= '0;
      else if (state != IDLE)
        timeline <= timeline + 1'b1;

      if (to_idle)
        label_time <= '0;
      else if (q_time_write)
        label_time <= label_time + {{(TW-20){1'b0}}, wait_val};

      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      ev_valid <= pop;
      if (pop) begin
        ev_type    <= head[PW+3:PW];
        ev_payload <= head[PW-1:0];
      end

      if (pop && (timeline > head_ts))
        late_err <= 1'b1;
      if (push_req && full && !pop)
        ovf_err <= 1'b1;
    end
  end

endmodule
